ofdm_cp_inserter: RTL

- Transmit-side stage directly downstream of the FFT core run with inverse=1 (IFFT).
- Consumes one time-domain OFDM symbol of N complex samples over the FFT's Avalon-ST source interface.
- Emits CP+N samples: the last CP samples (cyclic prefix) followed by the whole symbol, framed with sop/eop for the DAC/upconversion path.
- Ping-pong buffering lets the next symbol be written while the current one is read out.

---
 rtl/ofdm_cp_inserter_pkg.sv | 9 +
 rtl/ofdm_cp_inserter_if.sv | 14 +
 rtl/ofdm_cp_inserter_cp_pingpong_ram.sv | 21 ++
 rtl/ofdm_cp_inserter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ofdm_cp_inserter_pkg.sv
// Shared constants and FSM state types for the OFDM cyclic-prefix inserter.
package ofdm_pkg;
  localparam int OFDM_N  = 64;
  localparam int OFDM_CP = 16;
  localparam int OFDM_W  = 8;

  typedef enum logic       {W_IDLE, W_FILL}         wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_CP, R_BODY}   rd_state_e;
endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// Avalon-ST style sample stream: one complex sample per beat with sop/eop framing.
interface ofdm_cp_inserter_if #(parameter int W = 8);
  logic         valid;
  logic         ready;
  logic         sop;
  logic         eop;
  logic [1:0]   error;
  logic [W-1:0] re;
  logic [W-1:0] im;
  logic [5:0]   exp;

  modport master (output valid, sop, eop, error, re, im, exp, input ready);
  modport slave  (input valid, sop, eop, error, re, im, exp, output ready);
endinterface

// File: rtl/ofdm_cp_inserter_cp_pingpong_ram.sv
// Two-bank sample store, address {bank, index}; read data registered, held while re=0.
module cp_pingpong_ram #(
  parameter int N  = 64,
  parameter int W  = 8,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2*W-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [2*W-1:0] rdata
);
  logic [2*W-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter: buffers N-sample symbols in ping-pong banks, emits CP+N framed beats.
// Optional OFDM_CP_EXP_OUT_EN forwards the per-frame block exponent on src.exp.
module ofdm_cp_inserter import ofdm_pkg::*; #(
  parameter int N  = OFDM_N,
  parameter int CP = OFDM_CP,
  parameter int W  = OFDM_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ofdm_cp_inserter_if.slave       snk,
  ofdm_cp_inserter_if.master      src,
  output logic [7:0]              drop_count
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST     = AW'(N - 1);
  localparam logic [AW-1:0] CP_START = AW'(N - CP);

  wr_state_e      wst_q, wst_d;
  logic [AW-1:0]  widx_q, widx_d, widx;
  logic           wbank_q, wbank_d, poison_q, poison_d, rdy_q, rdy_d, bad, we;
  logic [1:0]     full_q, full_d, drop_inc;
  logic [7:0]     drop_q, drop_d;
  logic [8:0]     drop_sum;

  rd_state_e      gst_q, gst_d;
  logic [AW-1:0]  gidx_q, gidx_d, ridx;
  logic           gbank_q, gbank_d, rbank_q, issue, g_sop, g_eop;
  logic           p1_vld_q, p1_sop_q, p1_eop_q, out_free, out_eop_fire;
  logic           src_vld_q, src_sop_q, src_eop_q;
  logic [W-1:0]   src_re_q, src_im_q;
  logic [2*W-1:0] rdata;

  assign snk.ready    = rdy_q;
  assign out_free     = !src_vld_q || src.ready;
  assign out_eop_fire = src_vld_q && src.ready && src_eop_q;

  // A sop beat always lands at index 0, which also covers a restart inside W_FILL.
  always_comb begin
    wst_d    = wst_q;
    widx_d   = widx_q;
    wbank_d  = wbank_q;
    poison_d = poison_q;
    full_d   = full_q;
    drop_inc = 2'd0;
    we       = 1'b0;
    widx     = snk.sop ? '0 : widx_q;
    bad      = (snk.error != 2'b00) || (poison_q && !snk.sop);
    if (snk.valid && rdy_q && (snk.sop || wst_q == W_FILL)) begin
      we = 1'b1;
      if (snk.sop && wst_q == W_FILL) drop_inc = drop_inc + 2'd1;
      if (snk.eop || widx == LAST) begin
        wst_d = W_IDLE;
        if (snk.eop && widx == LAST && !bad) begin
          full_d[wbank_q] = 1'b1;
          wbank_d         = !wbank_q;
        end else begin
          drop_inc = drop_inc + 2'd1;
        end
      end else begin
        wst_d    = W_FILL;
        widx_d   = widx + AW'(1);
        poison_d = bad;
      end
    end
    if (out_eop_fire) full_d[rbank_q] = 1'b0;
    rdy_d    = !full_d[wbank_d];
    drop_sum = {1'b0, drop_q} + 9'(drop_inc);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // The read generator runs ahead of the output register, so it tracks its own bank
  // and may start the next full bank while the previous eop is still in flight.
  always_comb begin
    gst_d   = gst_q;
    gidx_d  = gidx_q;
    gbank_d = gbank_q;
    ridx    = (gst_q == R_IDLE) ? CP_START : gidx_q;
    g_sop   = (gst_q == R_IDLE);
    g_eop   = (gst_q == R_BODY) && (ridx == LAST);
    issue   = ((gst_q != R_IDLE) || full_q[gbank_q]) && (out_free || !p1_vld_q);
    if (issue) begin
      if (gst_q == R_BODY) begin
        gidx_d = ridx + AW'(1);
        if (g_eop) begin
          gst_d   = R_IDLE;
          gbank_d = !gbank_q;
        end
      end else if (ridx == LAST) begin
        gst_d  = R_BODY;
        gidx_d = '0;
      end else begin
        gst_d  = R_CP;
        gidx_d = ridx + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wst_q <= W_IDLE;  widx_q <= '0;  wbank_q <= 1'b0;  poison_q <= 1'b0;
      full_q <= '0;     rdy_q <= 1'b0; drop_q <= '0;
      gst_q <= R_IDLE;  gidx_q <= '0;  gbank_q <= 1'b0;  rbank_q <= 1'b0;
      p1_vld_q <= 1'b0; p1_sop_q <= 1'b0; p1_eop_q <= 1'b0;
      src_vld_q <= 1'b0; src_sop_q <= 1'b0; src_eop_q <= 1'b0;
      src_re_q <= '0;   src_im_q <= '0;
    end else begin
      wst_q <= wst_d;   widx_q <= widx_d; wbank_q <= wbank_d; poison_q <= poison_d;
      full_q <= full_d; rdy_q <= rdy_d;   drop_q <= drop_d;
      gst_q <= gst_d;   gidx_q <= gidx_d; gbank_q <= gbank_d;
      if (out_eop_fire) rbank_q <= !rbank_q;
      if (issue) begin
        p1_vld_q <= 1'b1; p1_sop_q <= g_sop; p1_eop_q <= g_eop;
      end else if (out_free) begin
        p1_vld_q <= 1'b0;
      end
      if (out_free) begin
        src_vld_q <= p1_vld_q;
        src_sop_q <= p1_vld_q && p1_sop_q;
        src_eop_q <= p1_vld_q && p1_eop_q;
        if (p1_vld_q) begin
          src_re_q <= rdata[2*W-1:W];
          src_im_q <= rdata[W-1:0];
        end
      end
    end
  end

  cp_pingpong_ram #(.N(N), .W(W), .AW(AW + 1)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wbank_q, widx}),
    .wdata ({snk.re, snk.im}),
    .re    (issue),
    .raddr ({gbank_q, ridx}),
    .rdata (rdata)
  );

  assign src.valid  = src_vld_q;
  assign src.sop    = src_sop_q;
  assign src.eop    = src_eop_q;
  assign src.re     = src_re_q;
  assign src.im     = src_im_q;
  assign src.error  = 2'b00;
  assign drop_count = drop_q;

`ifdef OFDM_CP_EXP_OUT_EN
  logic [1:0][5:0] bexp_q;
  logic            p1_bank_q;
  logic [5:0]      src_exp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bexp_q <= '0; p1_bank_q <= 1'b0; src_exp_q <= '0;
    end else begin
      if (we && snk.sop) bexp_q[wbank_q] <= snk.exp;
      if (issue) p1_bank_q <= gbank_q;
      if (out_free && p1_vld_q) src_exp_q <= bexp_q[p1_bank_q];
    end
  end
  assign src.exp = src_exp_q;
`else
  // Exponent lane is not carried; the source side drives it low.
  logic unused_exp;
  assign unused_exp = ^snk.exp;
  assign src.exp    = '0;
`endif
endmodule
